// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the push-button conditioner: FSM state codes,
// default debounce length and a population-count helper.
package pkg_condicionador;

  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
  localparam int MAX_BOTOES             = 32;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    PRESSIONADO = 2'd1,
    INVALIDO    = 2'd2
  } estado_t;

  // Button vectors narrower than MAX_BOTOES are zero-extended by the caller.
  function automatic logic [5:0] popcount(input logic [MAX_BOTOES-1:0] v);
    logic [5:0] soma;
    soma = '0;
    for (int i = 0; i < MAX_BOTOES; i++) begin
      soma = soma + {5'b0, v[i]};
    end
    return soma;
  endfunction

endpackage

// File: rtl/condicionador_botoes_debouncer_bit.sv
// One-bit synchroniser (two flops) followed by a counter debouncer:
// the stable level follows the input only after DEBOUNCE_CICLOS agreeing samples.
module debouncer_bit #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic estavel
);

  localparam int                CONT_W  = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CONT_W-1:0] CNT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic              s1_q;
  logic              s2_q;
  logic              estavel_q;
  logic [CONT_W-1:0] cnt_q;

  // Any sample agreeing with the stable level restarts the count, so glitches never land.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      estavel_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q <= entrada;
      s2_q <= s1_q;
      if (s2_q == estavel_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        estavel_q <= s2_q;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign estavel = estavel_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Debounces the play buttons and the start button, then accepts exactly one
// pressed button as a held one-hot jogada with a one-cycle acceptance strobe.
module condicionador_botoes
  import pkg_condicionador::*;
#(
  parameter int N_BOTOES        = 8,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  input  logic                jogar_bruto,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_pulso,
  output logic                jogar,
  output logic                multiplo,
  output logic [N_BOTOES-1:0] botoes_limpos,
  output logic [3:0]          db_estado
);

  logic [N_BOTOES:0]   brutos_w;
  logic [N_BOTOES:0]   estavel_w;
  logic [N_BOTOES-1:0] limpos_w;
  logic [5:0]          n_ativos;

  assign brutos_w = {jogar_bruto, botoes_brutos};
  assign limpos_w = estavel_w[N_BOTOES-1:0];
  assign n_ativos = popcount(MAX_BOTOES'(limpos_w));

  for (genvar i = 0; i <= N_BOTOES; i++) begin : g_db
    debouncer_bit #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .entrada (brutos_w[i]),
      .estavel (estavel_w[i])
    );
  end

  logic jogar_est_d_q;
  logic jogar_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogar_est_d_q <= 1'b0;
      jogar_q       <= 1'b0;
    end else begin
      jogar_est_d_q <= estavel_w[N_BOTOES];
      jogar_q       <= estavel_w[N_BOTOES] & ~jogar_est_d_q;
    end
  end

  estado_t             estado_q, estado_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                pulso_q, pulso_d;
  logic                ignorado_q, ignorado_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      jogada_q   <= '0;
      pulso_q    <= 1'b0;
      ignorado_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      jogada_q   <= jogada_d;
      pulso_q    <= pulso_d;
      ignorado_q <= ignorado_d;
    end
  end

  // A press seen while disabled stays blocked until every button is released.
  always_comb begin
    estado_d   = estado_q;
    jogada_d   = jogada_q;
    pulso_d    = 1'b0;
    ignorado_d = ignorado_q;
    if (n_ativos == 6'd0) begin
      ignorado_d = 1'b0;
    end else if (!habilita && (estado_q == OCIOSO)) begin
      ignorado_d = 1'b1;
    end
    case (estado_q)
      OCIOSO: begin
        if (n_ativos >= 6'd2) begin
          estado_d = INVALIDO;
        end else if ((n_ativos == 6'd1) && habilita && !ignorado_q) begin
          estado_d = PRESSIONADO;
          jogada_d = limpos_w;
          pulso_d  = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (n_ativos == 6'd0) begin
          estado_d = OCIOSO;
          jogada_d = '0;
        end
      end
      INVALIDO: begin
        jogada_d = '0;
        if (n_ativos == 6'd0) estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
        jogada_d = '0;
      end
    endcase
  end

  assign jogada        = jogada_q;
  assign jogada_pulso  = pulso_q;
  assign jogar         = jogar_q;
  assign multiplo      = (estado_q == INVALIDO);
  assign botoes_limpos = limpos_w;
  assign db_estado     = {2'b00, estado_q};

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with a short debounce: a window-based reference
// model checked every cycle, an expected-pulse queue and directed literal checks.
module tb_condicionador_botoes;

  localparam int N = 8;
  localparam int D = 4;

  logic         clock         = 1'b0;
  logic         reset         = 1'b0;
  logic [N-1:0] botoes_brutos = '0;
  logic         jogar_bruto   = 1'b0;
  logic         habilita      = 1'b0;
  logic [N-1:0] jogada;
  logic         jogada_pulso;
  logic         jogar;
  logic         multiplo;
  logic [N-1:0] botoes_limpos;
  logic [3:0]   db_estado;

  condicionador_botoes #(
    .N_BOTOES        (N),
    .DEBOUNCE_CICLOS (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes_brutos (botoes_brutos),
    .jogar_bruto   (jogar_bruto),
    .habilita      (habilita),
    .jogada        (jogada),
    .jogada_pulso  (jogada_pulso),
    .jogar         (jogar),
    .multiplo      (multiplo),
    .botoes_limpos (botoes_limpos),
    .db_estado     (db_estado)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_jogar = 0;
  int e;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the synchronised samples of the last D cycles all
  // agree on a value different from the current stable level.
  logic [N:0]   m_hist[$];
  logic [N:0]   m_est;
  logic         m_est_d;
  logic         m_jogar;
  logic         m_pulso;
  logic         m_ign;
  logic         m_ign_n;
  logic [N-1:0] m_jogada;
  int           m_estado;
  int           m_n;
  bit           m_ok;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < D + 2; i++) m_hist.push_back('0);
    m_est    = '0;
    m_est_d  = 1'b0;
    m_jogar  = 1'b0;
    m_pulso  = 1'b0;
    m_ign    = 1'b0;
    m_jogada = '0;
    m_estado = 0;
  endtask

  task automatic model_step();
    m_n     = $countones(m_est[N-1:0]);
    m_ign_n = (m_n == 0) ? 1'b0 : ((!habilita && m_estado == 0) ? 1'b1 : m_ign);
    m_pulso = 1'b0;
    case (m_estado)
      0: begin
        if (m_n >= 2) m_estado = 2;
        else if (m_n == 1 && habilita && !m_ign) begin
          m_estado = 1;
          m_jogada = m_est[N-1:0];
          m_pulso  = 1'b1;
        end
      end
      1: if (m_n == 0) begin m_estado = 0; m_jogada = '0; end
      default: if (m_n == 0) m_estado = 0;
    endcase
    m_ign   = m_ign_n;
    m_jogar = m_est[N] & ~m_est_d;
    m_est_d = m_est[N];
    m_hist.push_front({jogar_bruto, botoes_brutos});
    void'(m_hist.pop_back());
    for (int b = 0; b <= N; b++) begin
      m_ok = 1'b1;
      for (int i = 3; i <= D + 1; i++) if (m_hist[i][b] != m_hist[2][b]) m_ok = 1'b0;
      if (m_ok && (m_hist[2][b] != m_est[b])) m_est[b] = m_hist[2][b];
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- scoreboard / compare ----------------
  logic [31:0] exp_q[$];

  initial forever begin
    @(negedge clock);
    chk("jogada",        jogada,        m_jogada);
    chk("jogada_pulso",  jogada_pulso,  m_pulso);
    chk("jogar",         jogar,         m_jogar);
    chk("multiplo",      multiplo,      (m_estado == 2) ? 32'd1 : 32'd0);
    chk("botoes_limpos", botoes_limpos, m_est[N-1:0]);
    chk("db_estado",     db_estado,     m_estado);
    if (jogada_pulso === 1'b1) begin
      if (exp_q.size() == 0) chk("pulso_extra", jogada_pulso, 0);
      else chk("pulso_ciclo", cyc, exp_q.pop_front());
    end
    if (jogar === 1'b1) n_jogar++;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    ciclos(3);
    chk("reset_jogada", jogada, 0);
    chk("reset_pulso", jogada_pulso, 0);
    chk("reset_multiplo", multiplo, 0);
    chk("reset_estado", db_estado, 0);
    chk("reset_limpos", botoes_limpos, 0);
    chk("reset_jogar", jogar, 0);
    reset = 1'b1;
    habilita = 1'b1;
    ciclos(3);

    // clean single press, held 20 cycles
    e = cyc;
    botoes_brutos = 8'b0000_0100;
    exp_q.push_back(e + 7);
    ciclos(6);
    chk("limpa_antes", jogada, 0);
    ciclos(1);
    chk("limpa_jogada", jogada, 8'b0000_0100);
    chk("limpa_pulso", jogada_pulso, 1);
    chk("limpa_estado", db_estado, 1);
    ciclos(13);
    botoes_brutos = '0;
    ciclos(6);
    chk("limpa_retida", jogada, 8'b0000_0100);
    ciclos(1);
    chk("limpa_solta", jogada, 0);
    ciclos(5);

    // bounce on bit0, then steady press
    for (int k = 0; k < 5; k++) begin
      botoes_brutos = (k % 2 == 0) ? 8'h01 : 8'h00;
      if (k < 4) ciclos(2);
    end
    exp_q.push_back(cyc + 7);
    ciclos(7);
    chk("bounce_jogada", jogada, 8'b0000_0001);
    ciclos(3);
    botoes_brutos = '0;
    ciclos(10);

    // two buttons together
    botoes_brutos = 8'b0010_0010;
    ciclos(7);
    chk("multi_flag", multiplo, 1);
    chk("multi_estado", db_estado, 2);
    chk("multi_jogada", jogada, 0);
    ciclos(3);
    botoes_brutos = '0;
    ciclos(8);
    chk("multi_fim_flag", multiplo, 0);
    chk("multi_fim_estado", db_estado, 0);
    ciclos(4);

    // press while disabled, enable mid-hold, then re-press
    habilita = 1'b0;
    botoes_brutos = 8'b0000_1000;
    ciclos(10);
    habilita = 1'b1;
    ciclos(10);
    chk("gate_estado", db_estado, 0);
    chk("gate_jogada", jogada, 0);
    botoes_brutos = '0;
    ciclos(10);
    botoes_brutos = 8'b0000_1000;
    exp_q.push_back(cyc + 7);
    ciclos(7);
    chk("gate_rejogada", jogada, 8'b0000_1000);
    ciclos(3);
    botoes_brutos = '0;
    ciclos(10);

    // second button while PRESSIONADO
    botoes_brutos = 8'b0000_0100;
    exp_q.push_back(cyc + 7);
    ciclos(10);
    botoes_brutos = 8'b0100_0100;
    ciclos(10);
    chk("extra_jogada", jogada, 8'b0000_0100);
    chk("extra_estado", db_estado, 1);
    botoes_brutos = 8'b0100_0000;
    ciclos(10);
    chk("extra_meia_jogada", jogada, 8'b0000_0100);
    chk("extra_meia_estado", db_estado, 1);
    botoes_brutos = '0;
    ciclos(8);
    chk("extra_fim_estado", db_estado, 0);
    chk("extra_fim_jogada", jogada, 0);
    ciclos(4);

    // async reset mid-press, button kept held, start button pressed on release
    botoes_brutos = 8'b0000_0100;
    exp_q.push_back(cyc + 7);
    ciclos(10);
    chk("rst_antes_estado", db_estado, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_jogada", jogada, 0);
    chk("rst_pulso", jogada_pulso, 0);
    chk("rst_multiplo", multiplo, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_limpos", botoes_limpos, 0);
    chk("rst_jogar", jogar, 0);
    ciclos(1);
    reset = 1'b1;
    jogar_bruto = 1'b1;
    exp_q.push_back(cyc + 7);
    ciclos(7);
    chk("rst_rejogada", jogada, 8'b0000_0100);
    chk("rst_jogar_pulso", jogar, 1);
    ciclos(1);
    chk("rst_jogar_fim", jogar, 0);
    ciclos(5);
    botoes_brutos = '0;
    jogar_bruto = 1'b0;
    ciclos(12);

    chk("jogar_contagem", n_jogar, 1);
    chk("pulsos_pendentes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
